ex_alu_rs: RTL and testbench

- Parametrised ALU execute stage with a built-in DEPTH-entry reservation station.
- Accepts issued integer ops whose operands may still be pending, captures results from the common data bus (CDB), and dispatches the lowest-index ready entry to a registered ALU. Throughput is one op per cycle.
- Produces register writeback and jump redirects.
- Sits between the issue/allocator stage and the regfile/CDB.

---
 rtl/ex_alu_rs_pkg.sv | 43 ++++
 rtl/ex_alu_core.sv | 99 +++++++++
 rtl/ex_alu_rs.sv | 204 ++++++++++++++++++++
 tb/tb_ex_alu_rs.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_alu_rs_pkg.sv
// ============================================================================
// Module      : ex_alu_rs_pkg
// Description : Shared types, op encodings and constants for the ALU execute
//               stage and its reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_alu_rs_pkg;

    typedef logic [5:0]  sinst_t;
    typedef logic [4:0]  regaddr_t;
    typedef logic [3:0]  regtag_t;
    typedef logic [31:0] word_t;

    localparam regtag_t UNLOCKED = 4'd0;
    localparam word_t   ZERO     = 32'd0;

    localparam sinst_t OP_ADD   = 6'd1;
    localparam sinst_t OP_SUB   = 6'd2;
    localparam sinst_t OP_SLL   = 6'd3;
    localparam sinst_t OP_SRL   = 6'd4;
    localparam sinst_t OP_SRA   = 6'd5;
    localparam sinst_t OP_SLT   = 6'd6;
    localparam sinst_t OP_SLTU  = 6'd7;
    localparam sinst_t OP_XOR   = 6'd8;
    localparam sinst_t OP_OR    = 6'd9;
    localparam sinst_t OP_AND   = 6'd10;
    localparam sinst_t OP_LUI   = 6'd11;
    localparam sinst_t OP_AUIPC = 6'd12;
    localparam sinst_t OP_JAL   = 6'd13;
    localparam sinst_t OP_JALR  = 6'd14;
    // Conditional branches; only executed when ALU_BRANCH_EN is defined.
    localparam sinst_t OP_BEQ   = 6'd16;
    localparam sinst_t OP_BNE   = 6'd17;
    localparam sinst_t OP_BLT   = 6'd18;
    localparam sinst_t OP_BGE   = 6'd19;
    localparam sinst_t OP_BLTU  = 6'd20;
    localparam sinst_t OP_BGEU  = 6'd21;

endpackage : ex_alu_rs_pkg

`default_nettype wire

// File: rtl/ex_alu_core.sv
// ============================================================================
// Module      : ex_alu_core
// Description : Combinational op -> (data, en_jmp, jmp_addr, wr) function.
//               Optional macro ALU_BRANCH_EN enables conditional branches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_alu_core
    import ex_alu_rs_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    output logic [XLEN-1:0] data,
    output logic            en_jmp,
    output logic [XLEN-1:0] jmp_addr,
    output logic            wr
);

    sinst_t     opc;
    logic [4:0] shamt;

    assign opc   = sinst_t'(op);
    assign shamt = y[4:0];

    always_comb begin
        data     = '0;
        en_jmp   = 1'b0;
        jmp_addr = '0;
        wr       = 1'b1;
        case (opc)
            OP_ADD:   data = x + y;
            OP_SUB:   data = x - y;
            OP_SLL:   data = x << shamt;
            OP_SRL:   data = x >> shamt;
            OP_SRA:   data = $signed(x) >>> shamt;
            OP_SLT:   data = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU:  data = {{(XLEN-1){1'b0}}, (x < y)};
            OP_XOR:   data = x ^ y;
            OP_OR:    data = x | y;
            OP_AND:   data = x & y;
            OP_LUI:   data = imm;
            OP_AUIPC: data = pc + imm;
            OP_JAL: begin
                data     = pc + XLEN'(4);
                en_jmp   = 1'b1;
                jmp_addr = pc + imm;
            end
            OP_JALR: begin
                data     = pc + XLEN'(4);
                en_jmp   = 1'b1;
                jmp_addr = (x + imm) & ~XLEN'(1);
            end
`ifdef ALU_BRANCH_EN
            OP_BEQ: begin
                wr       = 1'b0;
                en_jmp   = (x == y);
                jmp_addr = pc + imm;
            end
            OP_BNE: begin
                wr       = 1'b0;
                en_jmp   = (x != y);
                jmp_addr = pc + imm;
            end
            OP_BLT: begin
                wr       = 1'b0;
                en_jmp   = ($signed(x) < $signed(y));
                jmp_addr = pc + imm;
            end
            OP_BGE: begin
                wr       = 1'b0;
                en_jmp   = ($signed(x) >= $signed(y));
                jmp_addr = pc + imm;
            end
            OP_BLTU: begin
                wr       = 1'b0;
                en_jmp   = (x < y);
                jmp_addr = pc + imm;
            end
            OP_BGEU: begin
                wr       = 1'b0;
                en_jmp   = (x >= y);
                jmp_addr = pc + imm;
            end
`endif
            // Unknown ops still write back (zero) so the entry retires.
            default: data = '0;
        endcase
    end

endmodule : ex_alu_core

`default_nettype wire

// File: rtl/ex_alu_rs.sv
// ============================================================================
// Module      : ex_alu_rs
// Description : ALU execute stage with a DEPTH-entry reservation station,
//               CDB wakeup and registered result. Macro ALU_BRANCH_EN
//               (inside ex_alu_core) enables conditional branches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_alu_rs
    import ex_alu_rs_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int OP_W  = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [OP_W-1:0]            issue_op,
    input  logic [XLEN-1:0]            issue_pc,
    input  logic [XLEN-1:0]            issue_imm,
    input  logic [TAG_W-1:0]           issue_tagx,
    input  logic [TAG_W-1:0]           issue_tagy,
    input  logic [XLEN-1:0]            issue_datax,
    input  logic [XLEN-1:0]            issue_datay,
    input  regaddr_t                   issue_target,
    input  logic [TAG_W-1:0]           issue_dtag,
    input  logic                       cdb_en,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [XLEN-1:0]            cdb_data,
    output logic                       wb_en,
    output regaddr_t                   wb_target,
    output logic [TAG_W-1:0]           wb_tag,
    output logic [XLEN-1:0]            wb_data,
    output logic                       en_jmp,
    output logic [XLEN-1:0]            jmp_addr,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam int               CNT_W    = $clog2(DEPTH+1);
    localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(UNLOCKED);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] valid_nxt;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] hit_x;
    logic [DEPTH-1:0] hit_y;

    logic [OP_W-1:0]  e_op     [DEPTH];
    logic [XLEN-1:0]  e_pc     [DEPTH];
    logic [XLEN-1:0]  e_imm    [DEPTH];
    logic [TAG_W-1:0] e_tagx   [DEPTH];
    logic [TAG_W-1:0] e_tagy   [DEPTH];
    logic [XLEN-1:0]  e_datax  [DEPTH];
    logic [XLEN-1:0]  e_datay  [DEPTH];
    regaddr_t         e_target [DEPTH];
    logic [TAG_W-1:0] e_dtag   [DEPTH];

    logic             cdb_live;
    logic             issue_fire;
    logic [IDX_W-1:0] alloc;
    logic [IDX_W-1:0] sel;
    logic             sel_found;
    logic [CNT_W-1:0] cnt;
    logic             in_hit_x;
    logic             in_hit_y;
    logic [XLEN-1:0]  op_x;
    logic [XLEN-1:0]  op_y;

    logic [XLEN-1:0]  core_data;
    logic             core_jmp;
    logic [XLEN-1:0]  core_addr;
    logic             core_wr;

    assign cdb_live    = cdb_en && (cdb_tag != TAG_NONE);
    assign occupancy   = cnt;
    assign issue_ready = (cnt < CNT_W'(DEPTH)) && !flush;
    assign issue_fire  = issue_valid && issue_ready && rdy;
    assign in_hit_x    = cdb_live && (issue_tagx == cdb_tag);
    assign in_hit_y    = cdb_live && (issue_tagy == cdb_tag);

    // Occupancy count and lowest-index free slot.
    always_comb begin
        cnt   = '0;
        alloc = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            cnt = cnt + CNT_W'(valid[i]);
            if (!valid[i]) alloc = IDX_W'(i);
        end
    end

    // A matching CDB broadcast counts as present this cycle, so the woken
    // entry dispatches in the broadcast cycle itself.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hit_x[i] = cdb_live && (e_tagx[i] == cdb_tag);
            hit_y[i] = cdb_live && (e_tagy[i] == cdb_tag);
            ready[i] = valid[i]
                     && ((e_tagx[i] == TAG_NONE) || hit_x[i])
                     && ((e_tagy[i] == TAG_NONE) || hit_y[i]);
            if (ready[i]) begin
                sel       = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    assign op_x = (e_tagx[sel] == TAG_NONE) ? e_datax[sel] : cdb_data;
    assign op_y = (e_tagy[sel] == TAG_NONE) ? e_datay[sel] : cdb_data;

    always_comb begin
        valid_nxt = valid;
        if (sel_found)  valid_nxt[sel]   = 1'b0;
        if (issue_fire) valid_nxt[alloc] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (rdy) begin
            valid <= flush ? '0 : valid_nxt;
        end
    end

    // Payload is only meaningful while valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rdy && !flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_fire && (alloc == IDX_W'(i))) begin
                    e_op[i]     <= issue_op;
                    e_pc[i]     <= issue_pc;
                    e_imm[i]    <= issue_imm;
                    e_tagx[i]   <= in_hit_x ? TAG_NONE : issue_tagx;
                    e_tagy[i]   <= in_hit_y ? TAG_NONE : issue_tagy;
                    e_datax[i]  <= in_hit_x ? cdb_data : issue_datax;
                    e_datay[i]  <= in_hit_y ? cdb_data : issue_datay;
                    e_target[i] <= issue_target;
                    e_dtag[i]   <= issue_dtag;
                end else begin
                    if (hit_x[i]) begin
                        e_tagx[i]  <= TAG_NONE;
                        e_datax[i] <= cdb_data;
                    end
                    if (hit_y[i]) begin
                        e_tagy[i]  <= TAG_NONE;
                        e_datay[i] <= cdb_data;
                    end
                end
            end
        end
    end

    ex_alu_core #(
        .XLEN (XLEN),
        .OP_W (OP_W)
    ) u_core (
        .op       (e_op[sel]),
        .pc       (e_pc[sel]),
        .imm      (e_imm[sel]),
        .x        (op_x),
        .y        (op_y),
        .data     (core_data),
        .en_jmp   (core_jmp),
        .jmp_addr (core_addr),
        .wr       (core_wr)
    );

    // wb_tag and jmp_addr keep their last values through idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en     <= 1'b0;
            wb_target <= '0;
            wb_tag    <= '0;
            wb_data   <= '0;
            en_jmp    <= 1'b0;
            jmp_addr  <= '0;
        end else if (rdy) begin
            if (flush || !sel_found) begin
                wb_en     <= 1'b0;
                wb_target <= '0;
                wb_data   <= '0;
                en_jmp    <= 1'b0;
            end else begin
                wb_en     <= core_wr;
                wb_target <= e_target[sel];
                wb_tag    <= e_dtag[sel];
                wb_data   <= core_data;
                en_jmp    <= core_jmp;
                if (core_jmp) jmp_addr <= core_addr;
            end
        end
    end

endmodule : ex_alu_rs

`default_nettype wire

// File: tb/tb_ex_alu_rs.sv
// ============================================================================
// Module      : tb_ex_alu_rs
// Description : Directed self-checking bench for ex_alu_rs (DEPTH=4, XLEN=32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_alu_rs;
    import ex_alu_rs_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, rdy, flush;
    logic        issue_valid, issue_ready;
    logic [5:0]  issue_op;
    logic [31:0] issue_pc, issue_imm, issue_datax, issue_datay;
    logic [3:0]  issue_tagx, issue_tagy, issue_dtag;
    logic [4:0]  issue_target;
    logic        cdb_en;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        wb_en;
    logic [4:0]  wb_target;
    logic [3:0]  wb_tag;
    logic [31:0] wb_data;
    logic        en_jmp;
    logic [31:0] jmp_addr;
    logic [2:0]  occupancy;

    int vectors = 0;
    int miscompares = 0;

    ex_alu_rs #(.XLEN(32), .DEPTH(4), .TAG_W(4), .OP_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_pc(issue_pc), .issue_imm(issue_imm),
        .issue_tagx(issue_tagx), .issue_tagy(issue_tagy),
        .issue_datax(issue_datax), .issue_datay(issue_datay),
        .issue_target(issue_target), .issue_dtag(issue_dtag),
        .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .wb_en(wb_en), .wb_target(wb_target), .wb_tag(wb_tag),
        .wb_data(wb_data), .en_jmp(en_jmp), .jmp_addr(jmp_addr),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_issue(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                               input logic [3:0] tx, input logic [3:0] ty,
                               input logic [31:0] dx, input logic [31:0] dy,
                               input logic [4:0] tgt, input logic [3:0] dtag);
        issue_valid  = 1'b1;
        issue_op     = op;
        issue_pc     = pc;
        issue_imm    = imm;
        issue_tagx   = tx;
        issue_tagy   = ty;
        issue_datax  = dx;
        issue_datay  = dy;
        issue_target = tgt;
        issue_dtag   = dtag;
    endtask

    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] x, input logic [31:0] y,
                          input logic exp_wb, input logic [31:0] exp_data,
                          input logic exp_jmp, input logic [31:0] exp_addr);
        drive_issue(op, pc, imm, 4'd0, 4'd0, x, y, 5'd1, 4'd6);
        step();
        issue_valid = 1'b0;
        step();
        check({tag, ".wb_en"}, 32'(wb_en), 32'(exp_wb));
        if (exp_wb) check({tag, ".data"}, wb_data, exp_data);
        check({tag, ".en_jmp"}, 32'(en_jmp), 32'(exp_jmp));
        if (exp_jmp) check({tag, ".jmp_addr"}, jmp_addr, exp_addr);
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
        issue_valid = 1'b0;
        drive_issue(6'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        issue_valid = 1'b0;
        cdb_en = 1'b0; cdb_tag = 4'd0; cdb_data = 32'd0;
        repeat (2) step();
        check("rst.wb_en", 32'(wb_en), 0);
        check("rst.wb_data", wb_data, 0);
        check("rst.wb_target", 32'(wb_target), 0);
        check("rst.wb_tag", 32'(wb_tag), 0);
        check("rst.en_jmp", 32'(en_jmp), 0);
        check("rst.jmp_addr", jmp_addr, 0);
        check("rst.occupancy", 32'(occupancy), 0);
        check("rst.issue_ready", 32'(issue_ready), 1);
        rst_n = 1'b1;
        step();

        // ADD 5 + 0xFFFFFFFF, two-cycle latency
        drive_issue(OP_ADD, 0, 0, 0, 0, 32'd5, 32'hFFFF_FFFF, 5'd7, 4'd9);
        step();
        issue_valid = 1'b0;
        check("add.early_wb_en", 32'(wb_en), 0);
        check("add.occ1", 32'(occupancy), 1);
        step();
        check("add.wb_en", 32'(wb_en), 1);
        check("add.data", wb_data, 32'd4);
        check("add.target", 32'(wb_target), 7);
        check("add.tag", 32'(wb_tag), 9);
        check("add.occ0", 32'(occupancy), 0);
        step();
        check("idle.wb_en", 32'(wb_en), 0);
        check("idle.wb_data", wb_data, 0);
        check("idle.wb_target", 32'(wb_target), 0);
        check("idle.wb_tag_hold", 32'(wb_tag), 9);

        // CDB tag 0 must not overwrite present operands
        drive_issue(OP_ADD, 0, 0, 0, 0, 32'd1, 32'd2, 5'd3, 4'd2);
        cdb_en = 1'b1; cdb_tag = 4'd0; cdb_data = 32'd100;
        step();
        issue_valid = 1'b0; cdb_en = 1'b0;
        step();
        check("tag0.data", wb_data, 32'd3);

        // SUB waiting on tag 3
        drive_issue(OP_SUB, 0, 0, 4'd3, 4'd0, 32'd0, 32'd4, 5'd2, 4'd5);
        step();
        issue_valid = 1'b0;
        step();
        check("sub.pending_wb_en", 32'(wb_en), 0);
        check("sub.pending_occ", 32'(occupancy), 1);
        cdb_en = 1'b1; cdb_tag = 4'd3; cdb_data = 32'd10;
        step();
        cdb_en = 1'b0;
        check("sub.wb_en", 32'(wb_en), 1);
        check("sub.data", wb_data, 32'd6);
        check("sub.tag", 32'(wb_tag), 5);
        check("sub.occ", 32'(occupancy), 0);

        // Fill all four entries with pending ops
        for (int k = 1; k <= 4; k++) begin
            drive_issue(OP_ADD, 0, 0, 4'(k), 4'd0, 32'd0, 32'd1, 5'(k), 4'(k + 8));
            step();
        end
        issue_valid = 1'b0;
        check("full.occ", 32'(occupancy), 4);
        check("full.issue_ready", 32'(issue_ready), 0);
        cdb_en = 1'b1; cdb_tag = 4'd3; cdb_data = 32'h10;
        step();
        cdb_en = 1'b0;
        check("wake.wb_en", 32'(wb_en), 1);
        check("wake.data", wb_data, 32'h11);
        check("wake.target", 32'(wb_target), 3);
        check("wake.occ", 32'(occupancy), 3);
        check("wake.issue_ready", 32'(issue_ready), 1);
        flush = 1'b1;
        #1;
        check("flush.issue_ready", 32'(issue_ready), 0);
        step();
        flush = 1'b0;
        check("flush1.occ", 32'(occupancy), 0);
        check("flush1.wb_en", 32'(wb_en), 0);

        // Execution unit vectors
        run_op("jalr", OP_JALR, 32'h100, 32'd4, 32'h203, 0, 1, 32'h104, 1, 32'h206);
        run_op("jal", OP_JAL, 32'h200, 32'h10, 0, 0, 1, 32'h204, 1, 32'h210);
        run_op("sll", OP_SLL, 0, 0, 32'd1, 32'd33, 1, 32'd2, 0, 0);
        run_op("srl", OP_SRL, 0, 0, 32'h8000_0000, 32'd4, 1, 32'h0800_0000, 0, 0);
        run_op("sra", OP_SRA, 0, 0, 32'h8000_0000, 32'd4, 1, 32'hF800_0000, 0, 0);
        run_op("slt", OP_SLT, 0, 0, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 0, 0);
        run_op("sltu", OP_SLTU, 0, 0, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 0, 0);
        run_op("xor", OP_XOR, 0, 0, 32'hF0F0, 32'hFF00, 1, 32'h0FF0, 0, 0);
        run_op("or", OP_OR, 0, 0, 32'hF0F0, 32'hFF00, 1, 32'hFFF0, 0, 0);
        run_op("and", OP_AND, 0, 0, 32'hF0F0, 32'hFF00, 1, 32'hF000, 0, 0);
        run_op("lui", OP_LUI, 0, 32'h1234_5000, 0, 0, 1, 32'h1234_5000, 0, 0);
        run_op("auipc", OP_AUIPC, 32'h1000, 32'h20, 0, 0, 1, 32'h1020, 0, 0);
        run_op("unknown", 6'h3F, 0, 0, 32'd7, 32'd7, 1, 32'd0, 0, 0);
        check("unknown.jmp_addr_hold", jmp_addr, 32'h210);
`ifdef ALU_BRANCH_EN
        run_op("blt", OP_BLT, 32'h40, 32'd8, 32'hFFFF_FFFF, 32'd1, 0, 0, 1, 32'h48);
        run_op("bge_nt", OP_BGE, 32'h40, 32'd8, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0);
`else
        run_op("blt_unk", OP_BLT, 32'h40, 32'd8, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 0, 0);
`endif

        // Flush with three wakeable entries and a concurrent issue
        for (int k = 0; k < 3; k++) begin
            drive_issue(OP_ADD, 0, 0, 4'd7, 4'd0, 32'd0, 32'd1, 5'd9, 4'd1);
            step();
        end
        drive_issue(OP_ADD, 0, 0, 4'd0, 4'd0, 32'd1, 32'd1, 5'd9, 4'd2);
        cdb_en = 1'b1; cdb_tag = 4'd7; cdb_data = 32'd5;
        flush = 1'b1;
        step();
        flush = 1'b0; issue_valid = 1'b0; cdb_en = 1'b0;
        check("flush.occ", 32'(occupancy), 0);
        check("flush.wb_en", 32'(wb_en), 0);
        step();
        check("flush.discard_wb_en", 32'(wb_en), 0);
        check("flush.discard_occ", 32'(occupancy), 0);

        // rdy=0 holds everything, including a ready entry
        drive_issue(OP_ADD, 0, 0, 0, 0, 32'd2, 32'd3, 5'd4, 4'd8);
        step();
        drive_issue(OP_ADD, 0, 0, 0, 0, 32'd10, 32'd1, 5'd5, 4'd9);
        step();
        check("rdy.pre_data", wb_data, 32'd5);
        check("rdy.pre_occ", 32'(occupancy), 1);
        rdy = 1'b0;
        drive_issue(OP_ADD, 0, 0, 0, 0, 32'd7, 32'd7, 5'd6, 4'd10);
        cdb_en = 1'b1; cdb_tag = 4'd4; cdb_data = 32'd0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rdy0.wb_en", 32'(wb_en), 1);
            check("rdy0.data", wb_data, 32'd5);
            check("rdy0.tag", 32'(wb_tag), 8);
            check("rdy0.occ", 32'(occupancy), 1);
        end
        rdy = 1'b1; issue_valid = 1'b0; cdb_en = 1'b0;
        step();
        check("rdy1.data", wb_data, 32'd11);
        check("rdy1.tag", 32'(wb_tag), 9);
        check("rdy1.occ", 32'(occupancy), 0);

        // Asynchronous reset mid-stream
        drive_issue(OP_ADD, 0, 0, 4'd5, 4'd0, 32'd0, 32'd1, 5'd2, 4'd3);
        step();
        drive_issue(OP_JAL, 32'h300, 32'd8, 0, 0, 0, 0, 5'd1, 4'd4);
        step();
        issue_valid = 1'b0;
        step();
        check("prerst.en_jmp", 32'(en_jmp), 1);
        check("prerst.jmp_addr", jmp_addr, 32'h308);
        check("prerst.occ", 32'(occupancy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.wb_en", 32'(wb_en), 0);
        check("arst.wb_data", wb_data, 0);
        check("arst.wb_tag", 32'(wb_tag), 0);
        check("arst.en_jmp", 32'(en_jmp), 0);
        check("arst.jmp_addr", jmp_addr, 0);
        check("arst.occ", 32'(occupancy), 0);
        rst_n = 1'b1;
        cdb_en = 1'b1; cdb_tag = 4'd5; cdb_data = 32'd1;
        step();
        cdb_en = 1'b0;
        check("postrst.wb_en", 32'(wb_en), 0);
        check("postrst.occ", 32'(occupancy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ex_alu_rs

`default_nettype wire
